uart_cmd_framer: RTL and testbench
==================================

// Module: uart_cmd_framer
// PURPOSE
//  Sequences the byte stream from the UART receiver into debugger commands: one opcode byte,
//  then 0 or WORD_BYTES payload bytes. Emits one framed command per valid/ready transfer to the
//  debug unit. Flags unknown opcodes, inter-byte timeouts and bytes arriving while output is held.
//  Sits between uart_rx (o_rx_done_tick/o_data, shared baud s_tick) and the debug control FSM.
// PARAMETERS
//  DBIT          8     bits per UART byte
//  WORD_BYTES    4     payload bytes of a LOAD command (payload width WORD_BYTES*DBIT)
//  TIMEOUT_TICKS 2048  baud s_ticks allowed between payload bytes before abort (>=2)
// PORTS
//  i_clk          in   1                  system clock
//  i_reset        in   1                  reset, synchronous, active-high
//  i_rx_done_tick in   1                  1-cycle pulse: i_rx_data holds a new byte
//  i_rx_data      in   DBIT               received byte
//  i_s_tick       in   1                  baud-rate generator tick (16x oversample)
//  i_ready        in   1                  consumer accepts command this cycle
//  o_valid        out  1                  framed command available
//  o_cmd          out  DBIT               opcode of framed command
//  o_payload      out  WORD_BYTES*DBIT    payload, little-endian (first byte in [DBIT-1:0]); 0 if none
//  o_err_opcode   out  1                  1-cycle pulse: unknown opcode dropped
//  o_err_timeout  out  1                  1-cycle pulse: partial frame aborted
//  o_err_overrun  out  1                  1-cycle pulse: byte dropped while o_valid held
//  o_busy         out  1                  1 when state != IDLE
// BEHAVIOUR
//  Reset (sync, i_clk edge with i_reset=1): state IDLE, all outputs 0, counters 0, payload 0.
//  States: IDLE, PAYLOAD, HOLD. All outputs registered.
//  IDLE: on i_rx_done_tick decode i_rx_data:
//   - LOAD opcode -> latch cmd, clear payload, byte_cnt=0, to_cnt=0, -> PAYLOAD.
//   - zero-payload opcode (STEP, CONT, RDREG, RDMEM, RESET) -> latch cmd, payload=0, -> HOLD.
//   - other -> o_err_opcode=1 next cycle, stay IDLE.
//  PAYLOAD: on i_rx_done_tick store byte at lane byte_cnt, to_cnt=0; when byte_cnt==WORD_BYTES-1
//   -> HOLD, else byte_cnt+1. Else on i_s_tick to_cnt+1; to_cnt==TIMEOUT_TICKS-1 with i_s_tick
//   -> o_err_timeout pulse, discard, -> IDLE. Byte and terminal tick same cycle: byte wins.
//  HOLD: o_valid=1, o_cmd/o_payload stable. Transfer when o_valid&i_ready -> IDLE, o_valid=0
//   next cycle. i_rx_done_tick in HOLD: byte dropped, o_err_overrun pulse (even if i_ready same cycle).
//  Latency: o_valid rises the cycle after the done tick of the final frame byte; i_ready may be
//   held high permanently -> o_valid is a 1-cycle pulse. No timeout in HOLD (waits indefinitely).
//  to_cnt width clog2(TIMEOUT_TICKS); byte_cnt width clog2(WORD_BYTES), never wraps.
//  Reset mid-frame: partial payload discarded, no error pulse, no o_valid.
// STRUCTURE
//  Shared header debug_cmds.vh: opcode localparams (LOAD=8'h4C 'L', STEP=8'h53 'S',
//   CONT=8'h43 'C', RDREG=8'h52 'R', RDMEM=8'h4D 'M', RESET=8'h58 'X') and state encodings;
//   debug-unit FSM includes the same header.
//  Single module, no sub-modules; opcode decode is a combinational function in this file.
// TESTING
//  'S' byte, i_ready=1 -> o_valid 1 cycle after done tick, o_cmd=8'h53, o_payload=0, o_busy=1 in HOLD.
//  'L',8'h13,8'h00,8'hA0,8'hE3 -> o_cmd=8'h4C, o_payload=32'hE3A00013; i_ready low 5 cycles -> held stable.
//  'L',8'h01, then 2048 s_ticks with no byte -> o_err_timeout single pulse, IDLE, no o_valid.
//  Byte 8'hFF in IDLE -> o_err_opcode pulse, state IDLE; next 'C' frames normally.
//  'S' held (i_ready=0), then byte 8'h43 arrives -> o_err_overrun pulse, o_cmd remains 8'h53.
//  i_reset after 'L',8'hAA,8'hBB -> all outputs 0 next cycle; following 'S' frames normally.

Source files
------------

// File: rtl/uart_cmd_framer_pkg.sv
// Shared opcode values, FSM state encoding and opcode classes for the UART
// command framer and the debug control FSM that consumes its commands.
package uart_cmd_framer_pkg;

    localparam logic [7:0] OP_LOAD  = 8'h4C;  // 'L'
    localparam logic [7:0] OP_STEP  = 8'h53;  // 'S'
    localparam logic [7:0] OP_CONT  = 8'h43;  // 'C'
    localparam logic [7:0] OP_RDREG = 8'h52;  // 'R'
    localparam logic [7:0] OP_RDMEM = 8'h4D;  // 'M'
    localparam logic [7:0] OP_RESET = 8'h58;  // 'X'

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OPK_BAD   = 2'd0,
        OPK_LOAD  = 2'd1,
        OPK_NOPAY = 2'd2
    } op_kind_t;

endpackage

// File: rtl/uart_cmd_framer.sv
// Frames the UART byte stream into debugger commands: an opcode byte plus an
// optional little-endian payload word, handed off over a valid/ready pair.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | waiting for an opcode byte
// ST_PAYLOAD | collecting LOAD payload bytes, inter-byte timeout running
// ST_HOLD    | command presented on o_valid until the consumer takes it
module uart_cmd_framer
    import uart_cmd_framer_pkg::*;
#(
    parameter int DBIT          = 8,
    parameter int WORD_BYTES    = 4,
    parameter int TIMEOUT_TICKS = 2048
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_rx_done_tick,
    input  logic [DBIT-1:0]            i_rx_data,
    input  logic                       i_s_tick,
    input  logic                       i_ready,
    output logic                       o_valid,
    output logic [DBIT-1:0]            o_cmd,
    output logic [WORD_BYTES*DBIT-1:0] o_payload,
    output logic                       o_err_opcode,
    output logic                       o_err_timeout,
    output logic                       o_err_overrun,
    output logic                       o_busy
);

    localparam int PW  = WORD_BYTES * DBIT;
    localparam int BCW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int TCW = $clog2(TIMEOUT_TICKS);
    localparam logic [BCW-1:0] LAST_LANE = BCW'(WORD_BYTES - 1);
    // Timeout is a down-counter: reload on every byte, fire on the tick seen at zero.
    localparam logic [TCW-1:0] TO_LOAD   = TCW'(TIMEOUT_TICKS - 1);

    function automatic op_kind_t decode_op(input logic [DBIT-1:0] b);
        op_kind_t k;
        k = OPK_BAD;
        if (b == DBIT'(OP_LOAD))
            k = OPK_LOAD;
        else if (b == DBIT'(OP_STEP)  || b == DBIT'(OP_CONT)  || b == DBIT'(OP_RDREG) ||
                 b == DBIT'(OP_RDMEM) || b == DBIT'(OP_RESET))
            k = OPK_NOPAY;
        return k;
    endfunction

    state_t          r_state,       w_state;
    logic [BCW-1:0]  r_byte_cnt,    w_byte_cnt;
    logic [TCW-1:0]  r_to_cnt,      w_to_cnt;
    logic [DBIT-1:0] r_cmd,         w_cmd;
    logic [PW-1:0]   r_payload,     w_payload;
    logic            r_valid,       w_valid;
    logic            r_err_opcode,  w_err_opcode;
    logic            r_err_timeout, w_err_timeout;
    logic            r_err_overrun, w_err_overrun;
    logic            r_busy,        w_busy;
    op_kind_t        w_op_kind;

    assign w_op_kind = decode_op(i_rx_data);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_byte_cnt    <= '0;
            r_to_cnt      <= '0;
            r_cmd         <= '0;
            r_payload     <= '0;
            r_valid       <= 1'b0;
            r_err_opcode  <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_byte_cnt    <= w_byte_cnt;
            r_to_cnt      <= w_to_cnt;
            r_cmd         <= w_cmd;
            r_payload     <= w_payload;
            r_valid       <= w_valid;
            r_err_opcode  <= w_err_opcode;
            r_err_timeout <= w_err_timeout;
            r_err_overrun <= w_err_overrun;
            r_busy        <= w_busy;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_byte_cnt    = r_byte_cnt;
        w_to_cnt      = r_to_cnt;
        w_cmd         = r_cmd;
        w_payload     = r_payload;
        w_valid       = 1'b0;
        w_err_opcode  = 1'b0;
        w_err_timeout = 1'b0;
        w_err_overrun = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_rx_done_tick) begin
                    case (w_op_kind)
                        OPK_LOAD: begin
                            w_cmd      = i_rx_data;
                            w_payload  = '0;
                            w_byte_cnt = '0;
                            w_to_cnt   = TO_LOAD;
                            w_state    = ST_PAYLOAD;
                        end
                        OPK_NOPAY: begin
                            w_cmd     = i_rx_data;
                            w_payload = '0;
                            w_valid   = 1'b1;
                            w_state   = ST_HOLD;
                        end
                        default: w_err_opcode = 1'b1;
                    endcase
                end
            end

            ST_PAYLOAD: begin
                // A byte landing on the terminal tick still counts.
                if (i_rx_done_tick) begin
                    for (int i = 0; i < WORD_BYTES; i++) begin
                        if (r_byte_cnt == BCW'(i))
                            w_payload[i*DBIT +: DBIT] = i_rx_data;
                    end
                    w_to_cnt = TO_LOAD;
                    if (r_byte_cnt == LAST_LANE) begin
                        w_valid = 1'b1;
                        w_state = ST_HOLD;
                    end else begin
                        w_byte_cnt = r_byte_cnt + 1'b1;
                    end
                end else if (i_s_tick) begin
                    if (r_to_cnt == '0) begin
                        w_err_timeout = 1'b1;
                        w_payload     = '0;
                        w_byte_cnt    = '0;
                        w_state       = ST_IDLE;
                    end else begin
                        w_to_cnt = r_to_cnt - 1'b1;
                    end
                end
            end

            ST_HOLD: begin
                w_valid = 1'b1;
                if (i_rx_done_tick)
                    w_err_overrun = 1'b1;
                if (i_ready) begin
                    w_valid = 1'b0;
                    w_state = ST_IDLE;
                end
            end

            default: w_state = ST_IDLE;
        endcase

        w_busy = (w_state != ST_IDLE);
    end

    assign o_valid       = r_valid;
    assign o_cmd         = r_cmd;
    assign o_payload     = r_payload;
    assign o_err_opcode  = r_err_opcode;
    assign o_err_timeout = r_err_timeout;
    assign o_err_overrun = r_err_overrun;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Directed self-checking bench for uart_cmd_framer: framing, hold/handshake,
// timeout boundary, opcode and overrun errors, and mid-frame reset.
module tb_uart_cmd_framer;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_rx_done_tick = 1'b0;
    logic [7:0]  i_rx_data = '0;
    logic        i_s_tick = 1'b0;
    logic        i_ready = 1'b0;
    logic        o_valid;
    logic [7:0]  o_cmd;
    logic [31:0] o_payload;
    logic        o_err_opcode;
    logic        o_err_timeout;
    logic        o_err_overrun;
    logic        o_busy;

    int n_checks = 0;
    int n_errors = 0;

    uart_cmd_framer #(.DBIT(8), .WORD_BYTES(4), .TIMEOUT_TICKS(2048)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_rx_done_tick (i_rx_done_tick),
        .i_rx_data      (i_rx_data),
        .i_s_tick       (i_s_tick),
        .i_ready        (i_ready),
        .o_valid        (o_valid),
        .o_cmd          (o_cmd),
        .o_payload      (o_payload),
        .o_err_opcode   (o_err_opcode),
        .o_err_timeout  (o_err_timeout),
        .o_err_overrun  (o_err_overrun),
        .o_busy         (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data      = b;
        i_rx_done_tick = 1'b1;
        cyc();
        i_rx_done_tick = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_valid"},   64'(o_valid), 64'h0);
        check_val({tag, "_busy"},    64'(o_busy), 64'h0);
        check_val({tag, "_cmd"},     64'(o_cmd), 64'h0);
        check_val({tag, "_payload"}, 64'(o_payload), 64'h0);
        check_val({tag, "_errs"},    64'({o_err_opcode, o_err_timeout, o_err_overrun}), 64'h0);
    endtask

    initial begin
        logic seen;

        // reset
        i_reset = 1'b1;
        cyc();
        cyc();
        i_reset = 1'b0;
        check_idle_outputs("rst");

        // 'S' with ready held high -> one-cycle valid pulse
        i_ready = 1'b1;
        send_byte(8'h53);
        check_val("s_valid",   64'(o_valid), 64'h1);
        check_val("s_cmd",     64'(o_cmd), 64'h53);
        check_val("s_payload", 64'(o_payload), 64'h0);
        check_val("s_busy",    64'(o_busy), 64'h1);
        cyc();
        check_val("s_valid_drop", 64'(o_valid), 64'h0);
        check_val("s_busy_drop",  64'(o_busy), 64'h0);

        // LOAD frame, consumer stalls five cycles
        i_ready = 1'b0;
        send_byte(8'h4C);
        send_byte(8'h13);
        send_byte(8'h00);
        send_byte(8'hA0);
        check_val("ld_partial_valid", 64'(o_valid), 64'h0);
        check_val("ld_partial_busy",  64'(o_busy), 64'h1);
        send_byte(8'hE3);
        check_val("ld_valid",   64'(o_valid), 64'h1);
        check_val("ld_cmd",     64'(o_cmd), 64'h4C);
        check_val("ld_payload", 64'(o_payload), 64'hE3A00013);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check_val("ld_hold_valid",   64'(o_valid), 64'h1);
            check_val("ld_hold_payload", 64'(o_payload), 64'hE3A00013);
        end
        i_ready = 1'b1;
        cyc();
        check_val("ld_xfer_valid", 64'(o_valid), 64'h0);
        i_ready = 1'b0;

        // timeout: 2047 ticks are tolerated, the 2048th aborts
        send_byte(8'h4C);
        send_byte(8'h01);
        i_s_tick = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 2047; i++) begin
            cyc();
            seen = seen | o_err_timeout;
        end
        check_val("to_early", 64'(seen), 64'h0);
        check_val("to_early_busy", 64'(o_busy), 64'h1);
        cyc();
        check_val("to_pulse", 64'(o_err_timeout), 64'h1);
        check_val("to_busy",  64'(o_busy), 64'h0);
        check_val("to_valid", 64'(o_valid), 64'h0);
        i_s_tick = 1'b0;
        cyc();
        check_val("to_pulse_end", 64'(o_err_timeout), 64'h0);
        check_val("to_no_valid",  64'(o_valid), 64'h0);

        // byte on the terminal tick wins over the timeout
        send_byte(8'h4C);
        i_s_tick = 1'b1;
        for (int i = 0; i < 2047; i++) cyc();
        send_byte(8'h11);
        i_s_tick = 1'b0;
        check_val("race_no_to", 64'(o_err_timeout), 64'h0);
        check_val("race_busy",  64'(o_busy), 64'h1);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        check_val("race_valid",   64'(o_valid), 64'h1);
        check_val("race_payload", 64'(o_payload), 64'h44332211);
        i_ready = 1'b1;
        cyc();
        i_ready = 1'b0;

        // unknown opcode, then a normal 'C'
        send_byte(8'hFF);
        check_val("op_err",   64'(o_err_opcode), 64'h1);
        check_val("op_busy",  64'(o_busy), 64'h0);
        check_val("op_valid", 64'(o_valid), 64'h0);
        cyc();
        check_val("op_err_end", 64'(o_err_opcode), 64'h0);
        send_byte(8'h43);
        check_val("c_valid",   64'(o_valid), 64'h1);
        check_val("c_cmd",     64'(o_cmd), 64'h43);
        check_val("c_payload", 64'(o_payload), 64'h0);
        i_ready = 1'b1;
        cyc();
        i_ready = 1'b0;

        // overrun while held, then overrun coinciding with transfer
        send_byte(8'h53);
        send_byte(8'h43);
        check_val("ovr_pulse", 64'(o_err_overrun), 64'h1);
        check_val("ovr_cmd",   64'(o_cmd), 64'h53);
        check_val("ovr_valid", 64'(o_valid), 64'h1);
        cyc();
        check_val("ovr_end", 64'(o_err_overrun), 64'h0);
        i_ready = 1'b1;
        send_byte(8'h58);
        check_val("ovr_xfer_pulse", 64'(o_err_overrun), 64'h1);
        check_val("ovr_xfer_valid", 64'(o_valid), 64'h0);
        check_val("ovr_xfer_busy",  64'(o_busy), 64'h0);
        i_ready = 1'b0;
        cyc();

        // reset mid-frame
        send_byte(8'h4C);
        send_byte(8'hAA);
        send_byte(8'hBB);
        i_reset = 1'b1;
        cyc();
        i_reset = 1'b0;
        check_idle_outputs("mid_rst");
        send_byte(8'h53);
        check_val("post_rst_valid",   64'(o_valid), 64'h1);
        check_val("post_rst_cmd",     64'(o_cmd), 64'h53);
        check_val("post_rst_payload", 64'(o_payload), 64'h0);
        i_ready = 1'b1;
        cyc();
        check_val("post_rst_xfer", 64'(o_valid), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
